// File: rtl/ecc_dec_pipe.sv
// Two-stage SECDED (39,32) decoder: stage 1 computes the syndrome and overall parity, stage 2 corrects and classifies.
// Saturating CE/UE statistics and first-error capture update only when a result is transferred downstream.
module ecc_dec_pipe #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [38:0]       in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ce,
  output logic              out_ue,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic              err_vld,
  output logic [ADDR_W-1:0] err_addr,
  output logic [5:0]        err_syn
);

  logic              s1_valid;
  logic [5:0]        s1_syn;
  logic              s1_par;
  logic [38:0]       s1_cw;
  logic [ADDR_W-1:0] s1_addr;
  logic [5:0]        out_syn;

  logic        s1_en;
  logic        s2_en;
  logic        xfer;
  logic [5:0]  syn_c;
  logic        ce_c;
  logic        ue_c;
  logic [38:0] flip_c;
  logic [38:0] fixed_c;

  function automatic logic [5:0] calc_syn(input logic [38:0] cw);
    logic [5:0] s;
    s = '0;
    for (int i = 1; i <= 38; i++) begin
      if (cw[6'(i - 1)]) s = s ^ 6'(i);
    end
    return s;
  endfunction

  // Data bits sit at the non-power-of-two Hamming positions, LSB first.
  function automatic logic [31:0] extract(input logic [38:0] cw);
    return {cw[37:32], cw[30:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;
  assign xfer     = out_valid && out_ready;
  assign syn_c    = calc_syn(in_cw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_cw    <= '0;
      s1_addr  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_syn  <= syn_c;
        s1_par  <= ^in_cw;
        s1_cw   <= in_cw;
        s1_addr <= in_addr;
      end
    end
  end

  // Syndrome 0 with bad parity means only the overall parity bit flipped.
  always_comb begin
    flip_c = '0;
    ce_c   = 1'b0;
    ue_c   = 1'b0;
    if (s1_par) begin
      if (s1_syn == 6'd0) begin
        ce_c = 1'b1;
      end else if (s1_syn <= 6'd38) begin
        ce_c   = 1'b1;
        flip_c = 39'd1 << (s1_syn - 6'd1);
      end else begin
        ue_c = 1'b1;
      end
    end else if (s1_syn != 6'd0) begin
      ue_c = 1'b1;
    end
    fixed_c = s1_cw ^ flip_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_ce    <= 1'b0;
      out_ue    <= 1'b0;
      out_syn   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= extract(fixed_c);
        out_addr <= s1_addr;
        out_ce   <= ce_c;
        out_ue   <= ue_c;
        out_syn  <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
      err_vld  <= 1'b0;
      err_addr <= '0;
      err_syn  <= '0;
    end else if (clr_stats) begin
      ce_count <= '0;
      ue_count <= '0;
      err_vld  <= 1'b0;
      err_addr <= '0;
      err_syn  <= '0;
    end else if (xfer) begin
      if (out_ce && ce_count != '1) ce_count <= ce_count + CNT_W'(1);
      if (out_ue && ue_count != '1) ue_count <= ue_count + CNT_W'(1);
      if ((out_ce || out_ue) && !err_vld) begin
        err_vld  <= 1'b1;
        err_addr <= out_addr;
        err_syn  <= out_syn;
      end
    end
  end

endmodule

// File: tb/tb_ecc_dec_pipe.sv
// Directed bench for ecc_dec_pipe: clean, CE, UE, backpressure, saturation/clear and mid-stream reset.
module tb_ecc_dec_pipe;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [38:0]       in_cw = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_ce;
  logic              out_ue;
  logic              clr_stats = 1'b0;
  logic [CNT_W-1:0]  ce_count;
  logic [CNT_W-1:0]  ue_count;
  logic              err_vld;
  logic [ADDR_W-1:0] err_addr;
  logic [5:0]        err_syn;

  always #5 clk = ~clk;

  ecc_dec_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_ce(out_ce), .out_ue(out_ue), .clr_stats(clr_stats),
    .ce_count(ce_count), .ue_count(ue_count),
    .err_vld(err_vld), .err_addr(err_addr), .err_syn(err_syn)
  );

  int total = 0;
  int bad = 0;
  int blocked = 0;

  logic [38:0]       tx_cw[$];
  logic [ADDR_W-1:0] tx_addr[$];
  logic [31:0]       rx_data[$];
  logic [ADDR_W-1:0] rx_addr[$];
  logic              rx_ce[$];
  logic              rx_ue[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[6'(p - 1)] = d[5'(k)];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (((p >> b) & 1) == 1) par = par ^ cw[6'(p - 1)];
      end
      cw[6'((1 << b) - 1)] = par;
    end
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  function automatic logic [38:0] bit_at(input int b);
    logic [38:0] m;
    m = '0;
    m[6'(b)] = 1'b1;
    return m;
  endfunction

  task automatic push(input logic [38:0] cw, input logic [ADDR_W-1:0] a);
    tx_cw.push_back(cw);
    tx_addr.push_back(a);
  endtask

  // Streams the tx queue, optionally toggling out_ready, until n_exp results were taken.
  task automatic run(input int n_exp, input bit toggle);
    int          cyc;
    bit          stalled;
    logic [63:0] prev;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    rx_data.delete(); rx_addr.delete(); rx_ce.delete(); rx_ue.delete();
    while (rx_data.size() < n_exp && cyc < 300) begin
      @(negedge clk);
      out_ready = toggle ? ~out_ready : 1'b1;
      if (tx_cw.size() > 0) begin
        in_valid = 1'b1;
        in_cw    = tx_cw[0];
        in_addr  = tx_addr[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) chk("stall_hold", {20'd0, out_data, out_addr, out_ce, out_ue}, prev);
      if (out_ready) chk("in_ready_hi", in_ready, 1);
      if (in_valid && !in_ready) blocked++;
      if (in_valid && in_ready) begin
        void'(tx_cw.pop_front());
        void'(tx_addr.pop_front());
      end
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_addr.push_back(out_addr);
        rx_ce.push_back(out_ce);
        rx_ue.push_back(out_ue);
      end
      stalled = out_valid && !out_ready;
      prev = {20'd0, out_data, out_addr, out_ce, out_ue};
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("run_count", rx_data.size(), n_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ce_ue", {out_ce, out_ue}, 0);
    chk("rst_counts", {ce_count, ue_count}, 0);
    chk("rst_err", {err_vld, err_addr, err_syn}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // T1 clean word, 2-cycle latency
    @(negedge clk);
    in_valid = 1'b1; in_cw = enc(32'd454); in_addr = 10'd4; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_lat1", out_valid, 0);
    @(negedge clk);
    chk("t1_lat2", out_valid, 1);
    chk("t1_data", out_data, 454);
    chk("t1_addr", out_addr, 4);
    chk("t1_flags", {out_ce, out_ue}, 0);
    @(negedge clk);
    chk("t1_drained", out_valid, 0);
    chk("t1_counts", {ce_count, ue_count}, 0);
    chk("t1_err_vld", err_vld, 0);

    // T2 single-bit errors, first capture sticks
    push(enc(32'd898) ^ bit_at(2), 10'd11);
    run(1, 1'b0);
    chk("t2_data", rx_data[0], 898);
    chk("t2_flags", {rx_ce[0], rx_ue[0]}, 2'b10);
    chk("t2_ce_count", ce_count, 1);
    chk("t2_err", {err_vld, err_addr, err_syn}, {1'b1, 10'd11, 6'd3});
    push(enc(32'd5) ^ bit_at(20), 10'd4);
    push(enc(32'd77) ^ bit_at(38), 10'd6);
    run(2, 1'b0);
    chk("t2b_data", rx_data[0], 5);
    chk("t2b_ce", rx_ce[0], 1);
    chk("t2c_data", rx_data[1], 77);
    chk("t2c_flags", {rx_ce[1], rx_ue[1]}, 2'b10);
    chk("t2b_ce_count", ce_count, 3);
    chk("t2b_err_keep", {err_addr, err_syn}, {10'd11, 6'd3});

    // T3 uncorrectable: double error, and triple error giving syndrome 41
    push(enc(32'd454) ^ bit_at(2) ^ bit_at(4), 10'd7);
    push(enc(32'd454) ^ bit_at(31) ^ bit_at(7) ^ bit_at(0), 10'd8);
    run(2, 1'b0);
    chk("t3_flags", {rx_ce[0], rx_ue[0]}, 2'b01);
    chk("t3_raw_data", rx_data[0], 32'd453);
    chk("t3b_flags", {rx_ce[1], rx_ue[1]}, 2'b01);
    chk("t3b_raw_data", rx_data[1], 32'd454);
    chk("t3_counts", {ce_count, ue_count}, {4'd3, 4'd2});

    // T4 backpressure with out_ready toggling
    blocked = 0;
    for (int i = 0; i < 8; i++) begin
      d = 32'h0101_0101 * (i + 1);
      push(enc(d), 10'(20 + i));
    end
    out_ready = 1'b1;
    run(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d = 32'h0101_0101 * (i + 1);
      chk("t4_data", rx_data[i], d);
      chk("t4_addr", rx_addr[i], 20 + i);
    end
    chk("t4_blocked", blocked > 0, 1);
    chk("t4_counts", {ce_count, ue_count}, {4'd3, 4'd2});

    // T5 clear, saturation, clear colliding with a CE transfer
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    chk("t5_clr_counts", {ce_count, ue_count}, 0);
    chk("t5_clr_err", err_vld, 0);
    for (int i = 0; i < 17; i++) push(enc(32'(100 + 3 * i)) ^ bit_at(i), 10'(50 + i));
    run(17, 1'b0);
    for (int i = 0; i < 17; i++) chk("t5_ce", rx_ce[i], 1);
    chk("t5_data16", rx_data[16], 148);
    chk("t5_sat", ce_count, 15);
    chk("t5_err", {err_vld, err_addr, err_syn}, {1'b1, 10'd50, 6'd1});
    @(negedge clk);
    in_valid = 1'b1; in_cw = enc(32'd33) ^ bit_at(10); in_addr = 10'd99; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_stalled", {out_valid, out_ce}, 2'b11);
    out_ready = 1'b1; clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("t5_clr_win", ce_count, 0);
    chk("t5_clr_err_win", err_vld, 0);
    chk("t5_xfer_done", out_valid, 0);

    // T6 reset with two words in flight
    push(enc(32'd9) ^ bit_at(5), 10'd3);
    run(1, 1'b0);
    chk("t6_pre_count", ce_count, 1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_cw = enc(32'd1); in_addr = 10'd1;
    @(negedge clk);
    in_cw = enc(32'd2); in_addr = 10'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_inflight", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_counts", {ce_count, ue_count}, 0);
    chk("t6_rst_err", {err_vld, err_addr, err_syn}, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t6_no_emit", seen, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_counts_after", {ce_count, ue_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
